// File: rtl/nibble_op_sequencer_pkg.sv
// rtl/nibble_op_sequencer_pkg.sv - shared ALU command/control types plus sequencer state and request types.
// NIBBLE_SEQ_MULTI_SHIFT_EN selects multi-pass right shifts.
package nibble_op_sequencer_pkg;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    COMP  = 3'd2,
    XNOR  = 3'd3,
    RSHFT = 3'd4
  } AluCmd;

  typedef struct packed {
    logic       carry_in;
    logic       invert_w2;
    logic [1:0] op_sel;
  } alu_ctrl_bits_t;

  typedef struct packed {
    AluCmd          cmd;
    alu_ctrl_bits_t ctrl;
  } AluCtrl;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } seq_state_t;

  typedef struct packed {
    AluCmd       cmd;
    logic [31:0] w1;
    logic [2:0]  nibbles;
    logic        signed_neg;
    logic        check_eq;
  } seq_req_t;

  function automatic AluCtrl cmd_to_ctrl(input AluCmd cmd);
    AluCtrl c;
    c.cmd            = cmd;
    c.ctrl.carry_in  = (cmd == SUB);
    c.ctrl.invert_w2 = (cmd == SUB) || (cmd == COMP);
    c.ctrl.op_sel    = (cmd == XNOR) ? 2'd1 : (cmd == RSHFT) ? 2'd2 : 2'd0;
    return c;
  endfunction

  // Without the multi-shift build every RSHFT is a single one-bit pass.
  function automatic logic [4:0] eff_shift_cnt(input logic [4:0] cnt);
`ifdef NIBBLE_SEQ_MULTI_SHIFT_EN
    return cnt;
`else
    return cnt & 5'd0 | 5'd1;
`endif
  endfunction

endpackage

// File: rtl/nibble_op_sequencer.sv
// rtl/nibble_op_sequencer.sv - request/response sequencer driving an external nibble-serial ALU loop.
// NIBBLE_SEQ_MULTI_SHIFT_EN enables repeated RSHFT passes and the zero-count bypass.
module nibble_op_sequencer
  import nibble_op_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  AluCmd       req_cmd,
  input  logic [31:0] req_w1,
  input  logic [31:0] req_w2,
  input  logic [2:0]  req_nibbles,
  input  logic        req_signed_neg,
  input  logic        req_check_eq,
  input  logic [4:0]  req_shift_cnt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        loop_perm_to_count,
  output logic [2:0]  loop_nibbles_number,
  output AluCtrl      ctrl,
  output logic        check_if_result_0xF,
  output logic        word2_is_signed_and_negative,
  output logic [31:0] word1,
  output logic [31:0] word2,
  output logic        enable_preinit_only,
  output logic [31:0] preinit_result,
  input  logic        loop_busy,
  input  logic [31:0] loop_result,
  input  logic        loop_carry
);

  seq_state_t  state;
  seq_req_t    req_q;
  logic [4:0]  shift_cnt;
  logic        bypass;

  assign word1                        = req_q.w1;
  assign loop_nibbles_number          = req_q.nibbles;
  assign check_if_result_0xF          = req_q.check_eq;
  assign word2_is_signed_and_negative = req_q.signed_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      req_q               <= '0;
      req_ready           <= 1'b1;
      rsp_valid           <= 1'b0;
      rsp_result          <= '0;
      rsp_carry           <= 1'b0;
      rsp_zero            <= 1'b1;
      loop_perm_to_count  <= 1'b0;
      enable_preinit_only <= 1'b0;
      preinit_result      <= '0;
      word2               <= '0;
      ctrl                <= '0;
      shift_cnt           <= '0;
      bypass              <= 1'b0;
    end else begin
      enable_preinit_only <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_q          <= '{cmd: req_cmd, w1: req_w1, nibbles: req_nibbles,
                                signed_neg: req_signed_neg, check_eq: req_check_eq};
            word2          <= req_w2;
            ctrl           <= cmd_to_ctrl(req_cmd);
            preinit_result <= (req_cmd == RSHFT) ? 32'd0 : req_w1;
            shift_cnt      <= eff_shift_cnt(req_shift_cnt);
            req_ready      <= 1'b0;
            state          <= ARM;
`ifdef NIBBLE_SEQ_MULTI_SHIFT_EN
            if (req_cmd == RSHFT && req_shift_cnt == 5'd0) begin
              bypass              <= 1'b1;
              enable_preinit_only <= 1'b1;
              preinit_result      <= req_w2;
            end
`endif
          end
        end
        ARM: begin
          if (bypass) begin
            // Zero-distance shift: the unshifted operand is the answer.
            bypass     <= 1'b0;
            rsp_result <= word2;
            rsp_carry  <= 1'b0;
            rsp_zero   <= (word2 == 32'd0);
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            loop_perm_to_count <= 1'b1;
            state              <= RUN;
          end
        end
        RUN: begin
          if (!loop_busy) begin
            loop_perm_to_count <= 1'b0;
            if (req_q.cmd == RSHFT && shift_cnt > 5'd1) begin
              shift_cnt <= shift_cnt - 5'd1;
              word2     <= loop_result;
              state     <= ARM;
            end else begin
              rsp_result <= loop_result;
              rsp_carry  <= loop_carry;
              rsp_zero   <= (loop_result == 32'd0);
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_op_sequencer.sv
// tb/tb_nibble_op_sequencer.sv - scoreboard bench with a behavioural nibble loop model.
module tb_nibble_op_sequencer;
  import nibble_op_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  AluCmd       req_cmd = ADD;
  logic [31:0] req_w1 = '0, req_w2 = '0;
  logic [2:0]  req_nibbles = '0;
  logic        req_signed_neg = 1'b0, req_check_eq = 1'b0;
  logic [4:0]  req_shift_cnt = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_zero;
  logic        loop_perm_to_count;
  logic [2:0]  loop_nibbles_number;
  AluCtrl      ctrl;
  logic        check_if_result_0xF, word2_is_signed_and_negative;
  logic [31:0] word1, word2, preinit_result;
  logic        enable_preinit_only;
  logic        loop_busy;
  logic [31:0] loop_result;
  logic        loop_carry;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] result;
    logic        carry;
    logic        zero;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  nibble_op_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_w1(req_w1), .req_w2(req_w2), .req_nibbles(req_nibbles),
    .req_signed_neg(req_signed_neg), .req_check_eq(req_check_eq), .req_shift_cnt(req_shift_cnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .loop_perm_to_count(loop_perm_to_count), .loop_nibbles_number(loop_nibbles_number),
    .ctrl(ctrl), .check_if_result_0xF(check_if_result_0xF),
    .word2_is_signed_and_negative(word2_is_signed_and_negative),
    .word1(word1), .word2(word2), .enable_preinit_only(enable_preinit_only),
    .preinit_result(preinit_result),
    .loop_busy(loop_busy), .loop_result(loop_result), .loop_carry(loop_carry)
  );

  // Nibble-serial loop model: one nibble per cycle while counting is permitted.
  logic [2:0] lcnt;
  function automatic logic [4:0] nib_step(input AluCmd cmd, input logic [31:0] a32, b32,
                                          input int i, input logic cin, sn);
    logic [3:0] a, b, nib;
    logic [4:0] s;
    logic [32:0] ext;
    logic c;
    a = a32[4*i +: 4];
    b = b32[4*i +: 4];
    ext = {sn, b32};
    nib = a;
    c = cin;
    case (cmd)
      ADD:  begin s = {1'b0, a} + {1'b0, b} + {4'd0, cin}; nib = s[3:0]; c = s[4]; end
      SUB:  begin s = {1'b0, a} + {1'b0, ~b} + {4'd0, cin}; nib = s[3:0]; c = s[4]; end
      COMP: begin s = {1'b0, a} + {1'b0, ~b} + {4'd0, cin}; c = s[4]; end
      XNOR: begin nib = ~(a ^ b); c = cin & (nib == 4'hF); end
      RSHFT: begin nib = {ext[4*i+4], b[3:1]}; c = (i == 0) ? b[0] : cin; end
      default: ;
    endcase
    return {c, nib};
  endfunction

  always @(posedge clk) begin
    if (!loop_perm_to_count) begin
      lcnt        <= 3'd0;
      loop_busy   <= 1'b1;
      loop_result <= preinit_result;
      loop_carry  <= (ctrl.cmd == XNOR) ? check_if_result_0xF : ctrl.ctrl.carry_in;
    end else if (loop_busy) begin
      logic [4:0] st;
      st = nib_step(ctrl.cmd, word1, word2, int'(lcnt), loop_carry, word2_is_signed_and_negative);
      loop_result[4*lcnt +: 4] <= st[3:0];
      loop_carry <= st[4];
      if (lcnt == loop_nibbles_number) loop_busy <= 1'b0;
      else lcnt <= lcnt + 3'd1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response handshake is presented.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_result"}, rsp_result, e.result);
        check({e.name, "_carry"}, {31'd0, rsp_carry}, {31'd0, e.carry});
        check({e.name, "_zero"}, {31'd0, rsp_zero}, {31'd0, e.zero});
      end
    end
  end

  task automatic send(input AluCmd cmd, input logic [31:0] w1, w2, input logic [2:0] n,
                      input logic sn, ce, input logic [4:0] sc, input bit has_rsp,
                      input logic [31:0] er, input logic ec, input string nm);
    int t = 0;
    while (!req_ready && t < 500) begin @(negedge clk); t++; end
    if (!req_ready) check({nm, "_req_ready_timeout"}, 32'd0, 32'd1);
    if (has_rsp) exp_q.push_back('{result: er, carry: ec, zero: (er == 32'd0), name: nm});
    req_cmd = cmd; req_w1 = w1; req_w2 = w2; req_nibbles = n;
    req_signed_neg = sn; req_check_eq = ce; req_shift_cnt = sc;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    int t;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_perm", {31'd0, loop_perm_to_count}, 32'd0);
    check("rst_preinit_only", {31'd0, enable_preinit_only}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd1);

    send(ADD, 32'h00ff0004, 32'h4, 3'd0, 1'b0, 1'b0, 5'd0, 1, 32'h00ff0008, 1'b0, "add_n0");
    check("add_preinit", preinit_result, 32'h00ff0004);
    send(SUB, 32'h1000, 32'h0500, 3'd7, 1'b0, 1'b0, 5'd0, 1, 32'h00000b00, 1'b1, "sub_n7");
    check("sub_carry_in", {31'd0, ctrl.ctrl.carry_in}, 32'd1);
    send(XNOR, 32'h12341234, 32'h12341234, 3'd7, 1'b0, 1'b1, 5'd0, 1, 32'hFFFFFFFF, 1'b1, "xnor_eq");
    check("xnor_check_flag", {31'd0, check_if_result_0xF}, 32'd1);
    send(XNOR, 32'h22341234, 32'h12341234, 3'd7, 1'b0, 1'b1, 5'd0, 1, 32'hCFFFFFFF, 1'b0, "xnor_ne");
    send(ADD, 32'h0, 32'h0, 3'd7, 1'b0, 1'b0, 5'd0, 1, 32'h0, 1'b0, "add_zero");
    check("add_carry_in", {31'd0, ctrl.ctrl.carry_in}, 32'd0);
`ifdef NIBBLE_SEQ_MULTI_SHIFT_EN
    send(RSHFT, 32'h0, 32'h06000000, 3'd7, 1'b0, 1'b0, 5'd4, 1, 32'h00600000, 1'b0, "rshft_cnt4");
    check("rshft_preinit", preinit_result, 32'h0);
    send(RSHFT, 32'h0, 32'h00001234, 3'd7, 1'b0, 1'b0, 5'd0, 1, 32'h00001234, 1'b0, "rshft_cnt0");
    check("bypass_preinit_only", {31'd0, enable_preinit_only}, 32'd1);
    check("bypass_preinit", preinit_result, 32'h00001234);
`else
    send(RSHFT, 32'h0, 32'h06000000, 3'd7, 1'b0, 1'b0, 5'd4, 1, 32'h03000000, 1'b0, "rshft_cnt4");
    check("rshft_preinit", preinit_result, 32'h0);
    send(RSHFT, 32'h0, 32'h00001234, 3'd7, 1'b0, 1'b0, 5'd0, 1, 32'h0000091A, 1'b0, "rshft_cnt0");
    check("no_preinit_only", {31'd0, enable_preinit_only}, 32'd0);
`endif
    send(RSHFT, 32'h0, 32'h80000010, 3'd7, 1'b1, 1'b0, 5'd1, 1, 32'hC0000008, 1'b0, "rshft_neg");

    // Response back-pressure: hold rsp_ready low and watch the outputs stay put.
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    rsp_ready = 1'b0;
    send(ADD, 32'h7, 32'h9, 3'd1, 1'b0, 1'b0, 5'd0, 1, 32'h10, 1'b0, "add_stall");
    t = 0;
    while (!rsp_valid && t < 500) begin @(negedge clk); t++; end
    check("stall_rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    held = rsp_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_result", rsp_result, held);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);

    // Reset during RUN abandons the operation silently.
    send(ADD, 32'h5, 32'h5, 3'd7, 1'b0, 1'b0, 5'd0, 0, 32'h0, 1'b0, "add_abandon");
    t = 0;
    while (!loop_perm_to_count && t < 500) begin @(negedge clk); t++; end
    check("run_reached", {31'd0, loop_perm_to_count}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_perm", {31'd0, loop_perm_to_count}, 32'd0);
    repeat (12) @(negedge clk);
    send(ADD, 32'h11111111, 32'h22222222, 3'd7, 1'b0, 1'b0, 5'd0, 1, 32'h33333333, 1'b0, "add_after_rst");

    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
